// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter.
// One instance per requester. The requester drives valid/we/addr/wdata and
// holds them until ready; the arbiter returns a one-cycle done strobe with
// rdata (read data on reads, zero on writes).
//   master : requester view (drives request, receives ready/done/rdata)
//   slave  : arbiter view
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, done, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, done, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory
// (synchronous write, registered read that only updates while WE=0).
// Requester 0 is the core load/store unit, requester 1 the loader/debug port.
// Each access takes IDLE (accept) -> ACCESS (memory cycle) -> RESP (done).
//
// Ports:
//   clk     clock, all logic on posedge
//   rst     synchronous active-high reset
//   r0, r1  requester buses (slave side of dmem_arbiter_if)
//   mem_WE  memory write enable (registered)
//   mem_A   memory byte address (registered, held between accesses)
//   mem_WD  memory write data (registered)
//   mem_RD  memory registered read data
//   busy    high whenever the FSM is not in IDLE
//
// state  | meaning
// IDLE   | waiting for a request; ready offered to the winner only
// ACCESS | memory performs the write or captures read data this cycle
// RESP   | done strobe (and read data) presented to the owner
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     r0,
  dmem_arbiter_if.slave     r1,
  output logic              mem_WE,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  input  logic [DATA_W-1:0] mem_RD,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0] state;
  logic       ptr;    // preferred requester when both are valid
  logic       owner;  // requester that owns the access in flight
  logic       we_q;   // kept past ACCESS because mem_WE drops before RESP
  logic       any_valid;
  logic       winner;
  logic       in_idle;
  logic       in_resp;

  always_comb begin
    any_valid = r0.valid | r1.valid;
    if (r0.valid && r1.valid) begin
      winner = ptr;
    end else begin
      winner = r1.valid;
    end
  end

  assign in_idle  = (state == IDLE);
  assign in_resp  = (state == RESP);
  assign busy     = !in_idle;

  assign r0.ready = in_idle && any_valid && !winner;
  assign r1.ready = in_idle && any_valid && winner;

  // Read data is only meaningful for the owner of a read; everything else
  // sees zero so a stale mem_RD never leaks to a requester.
  assign r0.done  = in_resp && !owner;
  assign r1.done  = in_resp && owner;
  assign r0.rdata = (in_resp && !owner && !we_q) ? mem_RD : '0;
  assign r1.rdata = (in_resp && owner && !we_q) ? mem_RD : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      owner  <= 1'b0;
      we_q   <= 1'b0;
      mem_WE <= 1'b0;
      mem_A  <= '0;
      mem_WD <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner <= winner;
            ptr   <= ~winner;
            if (winner) begin
              we_q   <= r1.we;
              mem_WE <= r1.we;
              mem_A  <= r1.addr;
              mem_WD <= r1.wdata;
            end else begin
              we_q   <= r0.we;
              mem_WE <= r0.we;
              mem_A  <= r0.addr;
              mem_WD <= r0.wdata;
            end
            state <= ACCESS;
          end else begin
            mem_WE <= 1'b0;
          end
        end
        ACCESS: begin
          // Address and data stay put; the memory's stray reads at the held
          // address in later cycles are ignored.
          mem_WE <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          mem_WE <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
